// File: rtl/scanner_pkg.sv
// Shared state encoding, widths and default timing for the channel scanner.
package scanner_pkg;

   localparam int CNT_W  = 8;
   localparam int CH_W   = 5;
   localparam int DATA_W = 12;

   localparam logic [5:0]        DEF_NUM_CH     = 6'd32;
   localparam logic [7:0]        DEF_SETTLE_CYC = 8'd4;
   localparam logic [3:0]        DEF_VALID_LEN  = 4'd3;
   localparam logic [3:0]        DEF_GAP_LEN    = 4'd2;
   localparam logic [7:0]        DEF_TIMEOUT    = 8'd200;
   localparam logic [DATA_W-1:0] TIMEOUT_DATA   = 12'hFFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      CONVERT = 3'd2,
      PRESENT = 3'd3,
      GAP     = 3'd4
   } scan_state_t;

   function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] ch,
                                                    input logic [5:0]      num_ch);
      if ({1'b0, ch} == num_ch - 6'd1)
         return '0;
      return ch + 5'd1;
   endfunction

endpackage

// File: rtl/down_counter.sv
// 8-bit loadable down counter; holds at zero and flags it.
module down_counter
   import scanner_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             decrement,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (decrement && (count != '0))
         count <= count - 8'd1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/channel_scanner.sv
// Sequential ADC channel scanner: settle, convert (with timeout), present
// each sample as a valid strobe, then a guaranteed low gap before the next.
module channel_scanner
   import scanner_pkg::*;
#(
   parameter logic [5:0] NUM_CH     = DEF_NUM_CH,
   parameter logic [7:0] SETTLE_CYC = DEF_SETTLE_CYC,
   parameter logic [3:0] VALID_LEN  = DEF_VALID_LEN,
   parameter logic [3:0] GAP_LEN    = DEF_GAP_LEN,
   parameter logic [7:0] TIMEOUT    = DEF_TIMEOUT
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_done,
   output logic              adc_start,
   output logic [CH_W-1:0]   mux_addr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic [CH_W-1:0]   address,
   output logic              frame_start,
   output logic              timeout_err
);

   localparam logic [CNT_W-1:0] VALID_LOAD = {4'd0, VALID_LEN - 4'd1};
   localparam logic [CNT_W-1:0] GAP_LOAD   = {4'd0, GAP_LEN - 4'd1};
   localparam logic [CNT_W-1:0] TMO_LOAD   = TIMEOUT - 8'd1;

   scan_state_t       state, state_nxt;
   logic [CH_W-1:0]   channel;

   logic              settle_load, settle_dec, settle_zero;
   logic              tmo_load, tmo_dec, tmo_zero;
   logic              vg_load, vg_dec, vg_zero;
   logic [CNT_W-1:0]  vg_val;
   logic              latch, latch_tmo, ch_adv;

   down_counter u_settle_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (settle_load),
      .load_val  (SETTLE_CYC),
      .decrement (settle_dec),
      .zero      (settle_zero)
   );

   down_counter u_timeout_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (tmo_load),
      .load_val  (TMO_LOAD),
      .decrement (tmo_dec),
      .zero      (tmo_zero)
   );

   // One counter serves both the valid-high and the gap-low phases.
   down_counter u_vg_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (vg_load),
      .load_val  (vg_val),
      .decrement (vg_dec),
      .zero      (vg_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      settle_load = 1'b0;
      settle_dec  = 1'b0;
      tmo_load    = 1'b0;
      tmo_dec     = 1'b0;
      vg_load     = 1'b0;
      vg_val      = VALID_LOAD;
      vg_dec      = 1'b0;
      latch       = 1'b0;
      latch_tmo   = 1'b0;
      ch_adv      = 1'b0;
      adc_start   = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               settle_load = 1'b1;
               state_nxt   = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_zero) begin
               adc_start = 1'b1;
               tmo_load  = 1'b1;
               state_nxt = CONVERT;
            end else begin
               settle_dec = 1'b1;
            end
         end
         CONVERT: begin
            if (adc_done || tmo_zero) begin
               latch     = 1'b1;
               latch_tmo = !adc_done;
               vg_load   = 1'b1;
               vg_val    = VALID_LOAD;
               state_nxt = PRESENT;
            end else begin
               tmo_dec = 1'b1;
            end
         end
         PRESENT: begin
            if (vg_zero) begin
               vg_load   = 1'b1;
               vg_val    = GAP_LOAD;
               state_nxt = GAP;
            end else begin
               vg_dec = 1'b1;
            end
         end
         GAP: begin
            if (vg_zero) begin
               ch_adv = 1'b1;
               if (enable) begin
                  settle_load = 1'b1;
                  state_nxt   = SETTLE;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               vg_dec = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         channel     <= '0;
         data        <= '0;
         address     <= '0;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (ch_adv)
            channel <= next_channel(channel, NUM_CH);
         if (latch) begin
            data    <= latch_tmo ? TIMEOUT_DATA : adc_data;
            address <= channel;
         end
         if (latch_tmo)
            timeout_err <= 1'b1;
         valid       <= (state_nxt == PRESENT);
         frame_start <= latch && (channel == '0);
      end
   end

   assign mux_addr = channel;

endmodule

// File: tb/tb_channel_scanner.sv
// Scoreboard bench: a default-parameter scanner and an 18-channel,
// zero-settle scanner, each driven by a behavioural ADC model.
module tb_channel_scanner;

   localparam int NCH_A = 32, NCH_B = 18;
   localparam int SETTLE_A = 4, SETTLE_B = 0;
   localparam int VLEN = 3, GLEN = 2, TMO = 200;
   localparam int DLY_A = 2, DLY_B = 1, HOLD_A = 1, HOLD_B = 4;

   typedef struct {
      int addr;
      int data;
      int lat;
      int start;
      bit to;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a, rst_b, en_a, en_b;
   logic [1:0]  adc_done = '0;
   logic [1:0]  adc_start, valid, frame_start, timeout_err;
   logic [11:0] adc_data [2];
   logic [11:0] data [2];
   logic [4:0]  mux_addr [2];
   logic [4:0]  address [2];

   channel_scanner #(.NUM_CH(6'd32), .SETTLE_CYC(8'd4), .VALID_LEN(4'd3),
                     .GAP_LEN(4'd2), .TIMEOUT(8'd200)) dut_a (
      .clk(clk), .reset(rst_a), .enable(en_a),
      .adc_data(adc_data[0]), .adc_done(adc_done[0]), .adc_start(adc_start[0]),
      .mux_addr(mux_addr[0]), .data(data[0]), .valid(valid[0]),
      .address(address[0]), .frame_start(frame_start[0]), .timeout_err(timeout_err[0])
   );

   channel_scanner #(.NUM_CH(6'd18), .SETTLE_CYC(8'd0), .VALID_LEN(4'd3),
                     .GAP_LEN(4'd2), .TIMEOUT(8'd200)) dut_b (
      .clk(clk), .reset(rst_b), .enable(en_b),
      .adc_data(adc_data[1]), .adc_done(adc_done[1]), .adc_start(adc_start[1]),
      .mux_addr(mux_addr[1]), .data(data[1]), .valid(valid[1]),
      .address(address[1]), .frame_start(frame_start[1]), .timeout_err(timeout_err[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_value(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   item_t q_a[$];
   item_t q_b[$];
   int pops[2], n_starts[2], exp_ch[2], dly[2], hold[2], hi_run[2], lo_run[2];
   int cur_ad[2], adc_ch[2];
   bit prev_v[2], exp_terr[2];
   bit no_ans_a = 1'b0;

   // ADC model and output monitor for both lanes
   always @(negedge clk) begin : lane
      logic  r;
      item_t it;
      int    nch, dl, hl, sz;
      for (int g = 0; g < 2; g++) begin
         r   = (g == 0) ? rst_a : rst_b;
         nch = (g == 0) ? NCH_A : NCH_B;
         dl  = (g == 0) ? DLY_A : DLY_B;
         hl  = (g == 0) ? HOLD_A : HOLD_B;
         if (!r) begin
            if (g == 0) q_a.delete(); else q_b.delete();
            dly[g] = 0; hold[g] = 0; adc_done[g] = 1'b0; adc_data[g] = 12'hABC;
            exp_ch[g] = 0; prev_v[g] = 1'b0; hi_run[g] = 0; lo_run[g] = GLEN;
            exp_terr[g] = 1'b0;
         end else begin
            if (hold[g] > 0) begin
               hold[g]--;
               if (hold[g] == 0) begin
                  adc_done[g] = 1'b0;
                  adc_data[g] = 12'hABC;
               end
            end
            if (dly[g] > 0) begin
               dly[g]--;
               if (dly[g] == 0) begin
                  adc_done[g] = 1'b1;
                  adc_data[g] = 12'(adc_ch[g] * 16);
                  hold[g]     = hl;
               end
            end
            if (adc_start[g]) begin
               check_value("mux_addr", int'(mux_addr[g]), exp_ch[g]);
               it.to    = (g == 0) && no_ans_a && (exp_ch[g] == 5);
               it.addr  = exp_ch[g];
               it.data  = it.to ? 32'hFFF : exp_ch[g] * 16;
               it.lat   = it.to ? TMO + 1 : dl + 1;
               it.start = cyc;
               if (g == 0) q_a.push_back(it); else q_b.push_back(it);
               if (!it.to) begin
                  dly[g]    = dl;
                  adc_ch[g] = int'(mux_addr[g]);
               end
               exp_ch[g] = (exp_ch[g] + 1) % nch;
               n_starts[g]++;
            end
            if (valid[g] && !prev_v[g]) begin
               sz = (g == 0) ? q_a.size() : q_b.size();
               check_value("sb_level", int'(sz > 0), 1);
               if (sz > 0) begin
                  if (g == 0) it = q_a.pop_front(); else it = q_b.pop_front();
                  if (it.to) exp_terr[g] = 1'b1;
                  check_value("address", int'(address[g]), it.addr);
                  check_value("data", int'(data[g]), it.data);
                  check_value("frame_start", int'(frame_start[g]), int'(it.addr == 0));
                  check_value("latency", cyc - it.start, it.lat);
                  check_value("timeout_err", int'(timeout_err[g]), int'(exp_terr[g]));
               end
               check_value("gap_len", int'(lo_run[g] >= GLEN), 1);
               cur_ad[g] = int'({address[g], data[g]});
               hi_run[g] = 1;
               pops[g]++;
            end else if (valid[g]) begin
               hi_run[g]++;
               check_value("hold_stable", int'({address[g], data[g]}), cur_ad[g]);
               check_value("frame_pulse", int'(frame_start[g]), 0);
            end else if (prev_v[g]) begin
               check_value("valid_len", hi_run[g], VLEN);
               lo_run[g] = 1;
            end else begin
               lo_run[g]++;
            end
            prev_v[g] = valid[g];
         end
      end
   end

   task automatic check_reset_state(input int g, input string pfx);
      check_value({pfx, "_data"}, int'(data[g]), 0);
      check_value({pfx, "_valid"}, int'(valid[g]), 0);
      check_value({pfx, "_address"}, int'(address[g]), 0);
      check_value({pfx, "_mux_addr"}, int'(mux_addr[g]), 0);
      check_value({pfx, "_adc_start"}, int'(adc_start[g]), 0);
      check_value({pfx, "_frame_start"}, int'(frame_start[g]), 0);
      check_value({pfx, "_timeout_err"}, int'(timeout_err[g]), 0);
   endtask

   task automatic wait_pops(input int g, input int n, input int budget, input string tag);
      int k = 0;
      while (pops[g] < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_value(tag, int'(pops[g] >= n), 1);
   endtask

   task automatic run_a();
      int k, j, n0, p0;
      rst_a = 1'b1;
      en_a  = 1'b1;
      #2 rst_a = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_state(0, "rst");
      @(negedge clk);
      rst_a = 1'b1;
      wait_pops(0, NCH_A + 1, 800, "scan_wrap");
      no_ans_a = 1'b1;
      wait_pops(0, NCH_A + 7, 800, "timeout_scan");
      no_ans_a = 1'b0;
      check_value("timeout_sticky", int'(timeout_err[0]), 1);
      wait_pops(0, 2 * NCH_A + 1, 800, "frame3");
      k = 0;
      while (!(adc_start[0] && mux_addr[0] == 5'd3) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_value("ch3_start", int'(adc_start[0] && mux_addr[0] == 5'd3), 1);
      @(negedge clk);
      en_a = 1'b0;
      n0   = n_starts[0];
      repeat (40) @(negedge clk);
      check_value("idle_no_start", n_starts[0], n0);
      check_value("idle_mux_addr", int'(mux_addr[0]), 4);
      check_value("idle_valid", int'(valid[0]), 0);
      check_value("idle_pops", pops[0], 2 * NCH_A + 4);
      j    = cyc;
      en_a = 1'b1;
      k    = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!adc_start[0] && k < 50);
      check_value("resume_start", cyc - j, SETTLE_A + 1);
      k = 0;
      while (!(valid[0] && address[0] == 5'd10) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_value("ch10_present", int'(valid[0] && address[0] == 5'd10), 1);
      p0 = pops[0];
      #1 rst_a = 1'b0;
      #1 check_reset_state(0, "rst_mid");
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      wait_pops(0, p0 + 4, 300, "restart");
   endtask

   task automatic run_b();
      int k, j;
      rst_b = 1'b1;
      en_b  = 1'b0;
      #2 rst_b = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_state(1, "b_rst");
      @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      check_value("b_idle_start", int'(adc_start[1]), 0);
      j    = cyc;
      en_b = 1'b1;
      k    = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!adc_start[1] && k < 20);
      check_value("b_first_start", cyc - j, SETTLE_B + 1);
      wait_pops(1, 2 * NCH_B + 2, 600, "b_wrap");
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
